mulacc_cxu: RTL and testbench
=============================

# mulacc_cxu

Fixed-latency CXU-L1 multiply-accumulate unit with per-state accumulators. It is the subordinate target that sits behind the L1-to-L2 feature level adapter. It accepts one request per enabled cycle with no backpressure and returns each response exactly `CXU_LATENCY` enabled cycles later, in order. Each of `CXU_N_STATES` contexts owns one `CXU_DATA_W`-bit accumulator.

## Interface
Parameters:
- `CXU_N_CXUS`, 1, number of CXUs addressed; `req_cxu` is ignored.
- `CXU_N_STATES`, 1, number of state contexts and accumulators; must be ≥1.
- `CXU_LATENCY`, 0, fixed response latency in `clk_en` cycles, 0..8.
- `CXU_RESET_LATENCY`, 0, must be 0.
- `CXU_FUNC_ID_W`, 10, function ID width.
- `CXU_DATA_W`, 32, operand and result width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `clk_en`  in  1  global clock enable; all state holds when low.
- `req_valid`  in  1  request present; no ready signal.
- `req_cxu`  in  max(1,clog2(N_CXUS))  ignored.
- `req_state`  in  max(1,clog2(N_STATES))  accumulator select.
- `req_func`  in  CXU_FUNC_ID_W  function ID.
- `req_data0`, `req_data1`  in  CXU_DATA_W  operands a, b.
- `resp_valid`  out  1  response present.
- `resp_status`  out  3  3'd0 = ok, 3'd1 = error.
- `resp_data`  out  CXU_DATA_W  result.

## Operation
- p = a*b, unsigned, full 2·DATA_W bits. acc = acc[req_state].
- func 0 MUL: result = p[DATA_W-1:0]; no accumulator change.
- func 1 MAC: acc ← acc + p; result = new acc.
- func 2 RDACC: result = acc.
- func 3 CLR: result = old acc; acc ← 0.
- func ≥4, or req_state ≥ N_STATES: status 3'd1, data 0, no accumulator change.
- Accumulator write commits at the end of the request cycle when `req_valid && clk_en`. A following MAC or RDACC to the same state on the next cycle sees the updated value at any latency.
- Arithmetic wraps modulo 2^DATA_W unless saturation is enabled (see Configuration).

## Timing
- LAT=0: responses are combinational. `resp_valid = req_valid && clk_en` in the same cycle. Status and data derive from pre-update accumulator values; MAC returns the sum.
- LAT≥1: a LAT-stage pipeline of {valid, status, data}. The first stage registers the computed result. The response asserts exactly LAT `clk_en`-high cycles after the request. Each stage advances only when `clk_en` is high.
- Throughput: one request per `clk_en` cycle. Responses are never reordered or dropped.
- Reset (LAT≥1): all pipeline valids, status and data clear to 0, so `resp_valid` = 0, `resp_status` = 0, `resp_data` = 0.
- Reset at any LAT: all accumulators clear to 0.
- Reset mid-operation: in-flight responses are discarded. `rst` takes priority over `clk_en` and over a concurrent request.
- `clk_en` low: requests are ignored, the pipeline freezes, and outputs hold.

## Configuration
- `MULACC_CXU_SATURATE_EN` defined: MAC saturates to all-ones when p[2·DATA_W-1:DATA_W] ≠ 0 or the sum carries out. MUL saturates likewise. Saturated responses still return status 0.
- `MULACC_CXU_SATURATE_EN` not defined: MUL and MAC wrap modulo 2^DATA_W, and the saturation logic is absent.

## Test plan
- LAT=2, N_STATES=2, DATA_W=32, MACs a=3,b=4 then a=5,b=6 on state 0, back-to-back → responses 12 and 42 exactly 2 and 3 cycles after the first request; RDACC on state 1 → 0.
- LAT=0: MUL a=0xFFFF_FFFF, b=2 → same-cycle response data 0xFFFF_FFFE. With `MULACC_CXU_SATURATE_EN` defined, the same stimulus → 0xFFFF_FFFF.
- MAC acc=0xFFFF_FFF0 plus p=0x20 → 0x0000_0010 wrap; with the macro defined → 0xFFFF_FFFF.
- func=7, or req_state=3 with N_STATES=2 → status 3'd1, data 0, and a subsequent RDACC shows the accumulator unchanged.
- LAT=3, random `clk_en` gaps → each response appears after exactly 3 enabled cycles, in order. CLR returns the old value, and the next RDACC returns 0.
- Assert `rst` with 3 responses in flight → `resp_valid` is 0 from the next cycle, no stale response emerges, and all accumulators read 0.

Source files
------------

// File: rtl/mulacc_cxu.sv
// Fixed-latency CXU-L1 multiply-accumulate unit with one accumulator per state context.
// Build option: define MULACC_CXU_SATURATE_EN for saturating MUL/MAC results.
module mulacc_cxu #(
  parameter int unsigned CXU_N_CXUS        = 1,
  parameter int unsigned CXU_N_STATES      = 1,
  parameter int unsigned CXU_LATENCY       = 0,
  parameter int unsigned CXU_RESET_LATENCY = 0,
  parameter int unsigned CXU_FUNC_ID_W     = 10,
  parameter int unsigned CXU_DATA_W        = 32
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       clk_en,
  input  logic                                                       req_valid,
  input  logic [((CXU_N_CXUS > 1) ? $clog2(CXU_N_CXUS) : 1)-1:0]     req_cxu,
  input  logic [((CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1)-1:0] req_state,
  input  logic [CXU_FUNC_ID_W-1:0]                                   req_func,
  input  logic [CXU_DATA_W-1:0]                                      req_data0,
  input  logic [CXU_DATA_W-1:0]                                      req_data1,
  output logic                                                       resp_valid,
  output logic [2:0]                                                 resp_status,
  output logic [CXU_DATA_W-1:0]                                      resp_data
);
  localparam int unsigned DW = CXU_DATA_W;
  localparam int unsigned PW = 2 * CXU_DATA_W;

  logic [DW-1:0] acc_q [CXU_N_STATES];
  logic [DW-1:0] acc_sel;
  logic [DW-1:0] acc_d;
  logic          acc_we;
  logic [PW-1:0] prod;
  logic [DW:0]   sum;
  logic          state_ok;
  logic          func_ok;
  logic [2:0]    status_d;
  logic [DW-1:0] data_d;
  logic          unused_ok;

  assign state_ok = 32'(req_state) < CXU_N_STATES;
  assign func_ok  = req_func < CXU_FUNC_ID_W'(4);
  assign acc_sel  = state_ok ? acc_q[req_state] : '0;
  assign prod     = PW'(req_data0) * PW'(req_data1);
  assign sum      = (DW+1)'(acc_sel) + (DW+1)'(prod[DW-1:0]);
  assign unused_ok = ^{req_cxu, prod[PW-1:DW], sum[DW], 1'(CXU_RESET_LATENCY)};

  // Result and accumulator write-back for the current request, from pre-update state.
  always_comb begin
    status_d = 3'd0;
    data_d   = '0;
    acc_we   = 1'b0;
    acc_d    = '0;
    if (!state_ok || !func_ok) begin
      status_d = 3'd1;
    end else begin
      case (req_func[1:0])
        2'd0: begin
          data_d = prod[DW-1:0];
`ifdef MULACC_CXU_SATURATE_EN
          if (|prod[PW-1:DW]) data_d = '1;
`endif
        end
        2'd1: begin
          acc_d = sum[DW-1:0];
`ifdef MULACC_CXU_SATURATE_EN
          if ((|prod[PW-1:DW]) || sum[DW]) acc_d = '1;
`endif
          acc_we = 1'b1;
          data_d = acc_d;
        end
        2'd2: data_d = acc_sel;
        default: begin
          data_d = acc_sel;
          acc_we = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CXU_N_STATES; i++) acc_q[i] <= '0;
    end else if (clk_en && req_valid && acc_we) begin
      acc_q[req_state] <= acc_d;
    end
  end

  if (CXU_LATENCY == 0) begin : g_comb
    assign resp_valid  = req_valid && clk_en;
    assign resp_status = status_d;
    assign resp_data   = data_d;
  end else begin : g_pipe
    logic          vld_q [CXU_LATENCY];
    logic [2:0]    sts_q [CXU_LATENCY];
    logic [DW-1:0] dat_q [CXU_LATENCY];

    // Response pipeline; every stage advances only on enabled cycles.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < CXU_LATENCY; i++) begin
          vld_q[i] <= 1'b0;
          sts_q[i] <= '0;
          dat_q[i] <= '0;
        end
      end else if (clk_en) begin
        vld_q[0] <= req_valid;
        sts_q[0] <= status_d;
        dat_q[0] <= data_d;
        for (int unsigned i = 1; i < CXU_LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          sts_q[i] <= sts_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign resp_valid  = vld_q[CXU_LATENCY-1];
    assign resp_status = sts_q[CXU_LATENCY-1];
    assign resp_data   = dat_q[CXU_LATENCY-1];
  end

endmodule

// File: tb/tb_mulacc_cxu.sv
// Bench for mulacc_cxu: three latency variants (0, 2, 3) share one request stream and are
// checked against an arithmetic model that indexes responses by enabled-cycle count.
module tb_mulacc_cxu;
  localparam int NS = 3;
  localparam int HN = 4096;
`ifdef MULACC_CXU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clk_en, req_valid;
  logic [0:0]  req_cxu;
  logic [1:0]  req_state;
  logic [9:0]  req_func;
  logic [31:0] req_data0, req_data1;
  logic [2:0]        rv;
  logic [2:0][2:0]   rs;
  logic [2:0][31:0]  rd;

  int nvec = 0;
  int nfail = 0;

  logic [31:0] acc_m [NS];
  logic        hv [HN];
  logic [2:0]  hs [HN];
  logic [31:0] hd [HN];
  int          ecnt = 0;

  always #5 clk = ~clk;

  mulacc_cxu #(.CXU_N_STATES(NS), .CXU_LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid), .req_cxu(req_cxu),
    .req_state(req_state), .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(rv[0]), .resp_status(rs[0]), .resp_data(rd[0]));
  mulacc_cxu #(.CXU_N_STATES(NS), .CXU_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid), .req_cxu(req_cxu),
    .req_state(req_state), .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(rv[1]), .resp_status(rs[1]), .resp_data(rd[1]));
  mulacc_cxu #(.CXU_N_STATES(NS), .CXU_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(req_valid), .req_cxu(req_cxu),
    .req_state(req_state), .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(rv[2]), .resp_status(rs[2]), .resp_data(rd[2]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  // Reference result of the request currently on the inputs, against the model accumulators.
  function automatic void model_eval(output logic [2:0] st, output logic [31:0] dt,
                                     output logic we, output logic [31:0] wv);
    longint unsigned a, b, p, acc, s;
    st = 3'd0; dt = 32'd0; we = 1'b0; wv = 32'd0;
    if (int'(req_func) > 3 || int'(req_state) >= NS) begin
      st = 3'd1;
    end else begin
      a = longint'(req_data0);
      b = longint'(req_data1);
      p = a * b;
      acc = longint'(acc_m[req_state]);
      s = acc + p;
      case (int'(req_func))
        0: dt = (SAT && p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(p);
        1: begin
          wv = (SAT && s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
          we = 1'b1;
          dt = wv;
        end
        2: dt = 32'(acc);
        default: begin
          dt = 32'(acc);
          we = 1'b1;
        end
      endcase
    end
  endfunction

  // Expected outputs of variant k at the current sampling point.
  function automatic void exp_out(input int k, output logic ev, output logic [2:0] es,
                                  output logic [31:0] ed, output logic chk);
    int l;
    logic we;
    logic [31:0] wv;
    l = lat_of(k);
    if (l == 0) begin
      model_eval(es, ed, we, wv);
      ev = req_valid && clk_en;
      chk = ev;
    end else if (ecnt >= l) begin
      ev = hv[(ecnt - l) % HN];
      es = hs[(ecnt - l) % HN];
      ed = hd[(ecnt - l) % HN];
      chk = ev;
    end else begin
      ev = 1'b0; es = 3'd0; ed = 32'd0; chk = 1'b1;
    end
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    logic [2:0] st;
    logic [31:0] dt, wv;
    logic we;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NS; i++) acc_m[i] = 32'd0;
      ecnt = 0;
    end else if (clk_en) begin
      model_eval(st, dt, we, wv);
      hv[ecnt % HN] = req_valid;
      hs[ecnt % HN] = st;
      hd[ecnt % HN] = dt;
      if (req_valid && we) acc_m[req_state] = wv;
      ecnt++;
    end
    #1;
  endtask

  task automatic drive(input logic en, input logic v, input int f, input int s,
                       input logic [31:0] a, input logic [31:0] b);
    clk_en = en; req_valid = v; req_func = 10'(f); req_state = 2'(s);
    req_data0 = a; req_data1 = b; req_cxu = 1'(s);
  endtask

  task automatic test_reset();
    logic ev, chk;
    logic [2:0] es;
    logic [31:0] ed;
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 32'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        exp_out(k, ev, es, ed, chk);
        nvec++;
        if (rv[k] !== ev || (chk && (rs[k] !== es || rd[k] !== ed))) begin
          nfail++;
          $display("FAIL reset lat%0d c%0d: got v=%b s=%0d d=%h want v=%b s=%0d d=%h",
                   lat_of(k), c, rv[k], rs[k], rd[k], ev, es, ed);
        end
      end
      tick();
    end
  endtask

  task automatic test_mac_sequence();
    logic ev, chk;
    logic [2:0] es;
    logic [31:0] ed;
    logic [31:0] want2 [5];
    want2[2] = 32'd12; want2[3] = 32'd42; want2[4] = 32'd0;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: drive(1'b1, 1'b1, 1, 0, 32'd3, 32'd4);
        1: drive(1'b1, 1'b1, 1, 0, 32'd5, 32'd6);
        2: drive(1'b1, 1'b1, 2, 1, 32'd0, 32'd0);
        default: drive(1'b1, 1'b0, 0, 0, 32'd0, 32'd0);
      endcase
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        exp_out(k, ev, es, ed, chk);
        nvec++;
        if (rv[k] !== ev || (chk && (rs[k] !== es || rd[k] !== ed))) begin
          nfail++;
          $display("FAIL mac_seq lat%0d c%0d: got v=%b s=%0d d=%h want v=%b s=%0d d=%h",
                   lat_of(k), c, rv[k], rs[k], rd[k], ev, es, ed);
        end
      end
      if (c >= 2 && c <= 4) begin
        nvec++;
        if (rv[1] !== 1'b1 || rd[1] !== want2[c]) begin
          nfail++;
          $display("FAIL mac_seq_lat2 c%0d: got v=%b d=%h want v=1 d=%h", c, rv[1], rd[1], want2[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic ev, chk;
    logic [2:0] es;
    logic [31:0] ed;
    logic [31:0] want;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(1'b1, 1'b1, 0, 0, 32'hFFFF_FFFF, 32'd2);
        1: drive(1'b1, 1'b1, 1, 2, 32'hFFFF_FFF0, 32'd1);
        2: drive(1'b1, 1'b1, 1, 2, 32'h20, 32'd1);
        default: drive(1'b1, 1'b0, 0, 0, 32'd0, 32'd0);
      endcase
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        exp_out(k, ev, es, ed, chk);
        nvec++;
        if (rv[k] !== ev || (chk && (rs[k] !== es || rd[k] !== ed))) begin
          nfail++;
          $display("FAIL wrap lat%0d c%0d: got v=%b s=%0d d=%h want v=%b s=%0d d=%h",
                   lat_of(k), c, rv[k], rs[k], rd[k], ev, es, ed);
        end
      end
      if (c == 0 || c == 2) begin
        if (c == 0) want = SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
        else        want = SAT ? 32'hFFFF_FFFF : 32'h0000_0010;
        nvec++;
        if (rv[0] !== 1'b1 || rs[0] !== 3'd0 || rd[0] !== want) begin
          nfail++;
          $display("FAIL wrap_lat0 c%0d: got v=%b s=%0d d=%h want v=1 s=0 d=%h", c, rv[0], rs[0], rd[0], want);
        end
      end
      tick();
    end
  endtask

  task automatic test_errors();
    logic ev, chk;
    logic [2:0] es;
    logic [31:0] ed;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drive(1'b1, 1'b1, 7, 0, 32'd9, 32'd9);
        1: drive(1'b1, 1'b1, 1, 3, 32'd5, 32'd5);
        2: drive(1'b1, 1'b1, 2, 0, 32'd0, 32'd0);
        3: drive(1'b1, 1'b1, 3, 3, 32'd0, 32'd0);
        default: drive(1'b1, 1'b0, 0, 0, 32'd0, 32'd0);
      endcase
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        exp_out(k, ev, es, ed, chk);
        nvec++;
        if (rv[k] !== ev || (chk && (rs[k] !== es || rd[k] !== ed))) begin
          nfail++;
          $display("FAIL errors lat%0d c%0d: got v=%b s=%0d d=%h want v=%b s=%0d d=%h",
                   lat_of(k), c, rv[k], rs[k], rd[k], ev, es, ed);
        end
      end
      if (c <= 2) begin
        nvec++;
        if (rs[0] !== ((c == 2) ? 3'd0 : 3'd1) || rd[0] !== ((c == 2) ? 32'd42 : 32'd0)) begin
          nfail++;
          $display("FAIL errors_lat0 c%0d: got s=%0d d=%h want s=%0d d=%h", c, rs[0], rd[0],
                   (c == 2) ? 3'd0 : 3'd1, (c == 2) ? 32'd42 : 32'd0);
        end
      end
      tick();
    end
  endtask

  task automatic test_random_gaps();
    logic ev, chk;
    logic [2:0] es;
    logic [31:0] ed;
    int f;
    for (int c = 0; c < 400; c++) begin
      if (c == 0)      drive(1'b1, 1'b1, 3, 2, 32'd0, 32'd0);
      else if (c == 1) drive(1'b0, 1'b1, 1, 2, 32'd7, 32'd7);
      else if (c == 2) drive(1'b1, 1'b1, 2, 2, 32'd0, 32'd0);
      else begin
        f = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 1023)) : int'($urandom_range(0, 3));
        drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, f,
              int'($urandom_range(0, 3)),
              $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 300)),
              $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 300)));
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        exp_out(k, ev, es, ed, chk);
        nvec++;
        if (rv[k] !== ev || (chk && (rs[k] !== es || rd[k] !== ed))) begin
          nfail++;
          $display("FAIL random lat%0d c%0d: got v=%b s=%0d d=%h want v=%b s=%0d d=%h",
                   lat_of(k), c, rv[k], rs[k], rd[k], ev, es, ed);
        end
      end
      if (c == 2) begin
        nvec++;
        if (rv[0] !== 1'b1 || rd[0] !== 32'd0) begin
          nfail++;
          $display("FAIL clr_then_rdacc: got v=%b d=%h want v=1 d=00000000", rv[0], rd[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_inflight();
    logic ev, chk;
    logic [2:0] es;
    logic [31:0] ed;
    for (int c = 0; c < 14; c++) begin
      rst = (c == 3);
      if (c <= 3)      drive(1'b1, 1'b1, 1, c % 3, 32'(c + 1), 32'd7);
      else if (c >= 8 && c <= 10) drive(1'b1, 1'b1, 2, c - 8, 32'd0, 32'd0);
      else             drive(1'b1, 1'b0, 0, 0, 32'd0, 32'd0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        exp_out(k, ev, es, ed, chk);
        nvec++;
        if (rv[k] !== ev || (chk && (rs[k] !== es || rd[k] !== ed))) begin
          nfail++;
          $display("FAIL rst_inflight lat%0d c%0d: got v=%b s=%0d d=%h want v=%b s=%0d d=%h",
                   lat_of(k), c, rv[k], rs[k], rd[k], ev, es, ed);
        end
      end
      if (c >= 4 && c <= 7) begin
        nvec++;
        if (rv[1] !== 1'b0 || rv[2] !== 1'b0) begin
          nfail++;
          $display("FAIL rst_flush c%0d: got v2=%b v3=%b want 0 0", c, rv[1], rv[2]);
        end
      end
      if (c >= 8 && c <= 10) begin
        nvec++;
        if (rv[0] !== 1'b1 || rd[0] !== 32'd0) begin
          nfail++;
          $display("FAIL rst_acc_clear st%0d: got v=%b d=%h want v=1 d=00000000", c - 8, rv[0], rd[0]);
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mac_sequence();
    test_wrap();
    test_errors();
    test_random_gaps();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
